// File: rtl/freq_channel_scheduler.sv
// Time-multiplexes NUM_CH asynchronous frequency inputs onto one shared frequency_counter,
// selecting enabled channels round-robin and handing each measurement out over a valid/ready port.
module freq_channel_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int EDGES_PER_MEAS = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     RUN,
    input  logic [NUM_CH-1:0]                        CH_EN,
    input  logic [NUM_CH-1:0]                        FREQ_IN_CH,
    output logic                                     FC_RST_N,
    output logic                                     FC_FREQ_IN,
    input  logic [31:0]                              FC_TIME_HIGH,
    input  logic [31:0]                              FC_TIME_LOW,
    input  logic [31:0]                              FC_PERIOD,
    output logic                                     RES_VALID,
    input  logic                                     RES_READY,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] RES_CH,
    output logic [31:0]                              RES_TIME_HIGH,
    output logic [31:0]                              RES_TIME_LOW,
    output logic [31:0]                              RES_PERIOD,
    output logic                                     RES_TIMEOUT
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EC_W = $clog2(EDGES_PER_MEAS + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SETTLE,
        S_OUTPUT
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NUM_CH-1:0]   sync_p0;
    logic [NUM_CH-1:0]   sync_p1;
    logic [NUM_CH-1:0]   sel_vec;
    logic [NUM_CH-1:0]   upper_en;
    logic                sel_bit;
    logic                sel_prev;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     pick;
    logic                go;
    logic                rise;
    logic                meas_done;
    logic                meas_timeout;
    logic                ph;
    logic [EC_W-1:0]     edge_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [CH_W-1:0]     res_ch;
    logic [31:0]         res_time_high;
    logic [31:0]         res_time_low;
    logic [31:0]         res_period;
    logic                res_timeout;

    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] t;
        lowest_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            t = v >> i;
            if (t[0]) lowest_set = CH_W'(i);
        end
    endfunction

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] c);
        wrap_inc = (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

    // Round-robin: prefer enabled channels at or above rr_ptr, otherwise wrap to the lowest one.
    always_comb begin
        upper_en = CH_EN & ~((NUM_CH'(1) << rr_ptr) - NUM_CH'(1));
        pick     = (upper_en != '0) ? lowest_set(upper_en) : lowest_set(CH_EN);
    end

    assign go           = RUN && (CH_EN != '0);
    assign sel_vec      = sync_p1 >> cur_ch;
    assign sel_bit      = sel_vec[0];
    assign rise         = sel_bit && !sel_prev;
    assign meas_done    = rise && (edge_cnt == EC_W'(EDGES_PER_MEAS - 1));
    assign meas_timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (go) state_nxt = S_CLEAR;
            S_CLEAR:   if (ph) state_nxt = S_MEASURE;
            S_MEASURE: begin
                if (meas_done)         state_nxt = S_SETTLE;
                else if (meas_timeout) state_nxt = S_OUTPUT;
            end
            S_SETTLE:  if (ph) state_nxt = S_OUTPUT;
            S_OUTPUT:  if (RES_READY) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs are gated with RST so they take their reset values while RST is held.
    always_comb begin
        FC_RST_N   = !RST && (state != S_CLEAR);
        FC_FREQ_IN = !RST && (state != S_IDLE) && sel_bit;
        RES_VALID  = !RST && (state == S_OUTPUT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            sel_prev      <= 1'b0;
            cur_ch        <= '0;
            rr_ptr        <= '0;
            ph            <= 1'b0;
            edge_cnt      <= '0;
            to_cnt        <= '0;
            res_ch        <= '0;
            res_time_high <= '0;
            res_time_low  <= '0;
            res_period    <= '0;
            res_timeout   <= 1'b0;
        end else begin
            // Stage p0/p1: two-flop synchronizer on every channel
            sync_p0  <= FREQ_IN_CH;
            sync_p1  <= sync_p0;
            sel_prev <= sel_bit;
            case (state)
                S_IDLE: begin
                    ph <= 1'b0;
                    if (go) begin
                        cur_ch <= pick;
                        rr_ptr <= wrap_inc(pick);
                    end
                end
                S_CLEAR: begin
                    ph       <= ~ph;
                    edge_cnt <= '0;
                    to_cnt   <= '0;
                end
                S_MEASURE: begin
                    ph     <= 1'b0;
                    to_cnt <= to_cnt + TO_W'(1);
                    if (rise) edge_cnt <= edge_cnt + EC_W'(1);
                    if (!meas_done && meas_timeout) begin
                        res_ch        <= cur_ch;
                        res_time_high <= '0;
                        res_time_low  <= '0;
                        res_period    <= '0;
                        res_timeout   <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    ph <= ~ph;
                    // Second settle cycle: the counter has published its final values.
                    if (ph) begin
                        res_ch        <= cur_ch;
                        res_time_high <= FC_TIME_HIGH;
                        res_time_low  <= FC_TIME_LOW;
                        res_period    <= FC_PERIOD;
                        res_timeout   <= 1'b0;
                    end
                end
                default: ph <= 1'b0;
            endcase
        end
    end

    assign RES_CH        = res_ch;
    assign RES_TIME_HIGH = res_time_high;
    assign RES_TIME_LOW  = res_time_low;
    assign RES_PERIOD    = res_period;
    assign RES_TIMEOUT   = res_timeout;

endmodule

// File: tb/tb_freq_channel_scheduler.sv
// Randomized self-checking bench for freq_channel_scheduler with a behavioural
// frequency counter and per-channel square-wave generators.
module tb_freq_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int TMO    = 100;

    logic        CLK;
    logic        RST;
    logic        RUN;
    logic [3:0]  CH_EN;
    logic [3:0]  freq;
    logic        FC_RST_N;
    logic        FC_FREQ_IN;
    logic [31:0] fc_th, fc_tl, fc_per;
    logic        RES_VALID;
    logic        RES_READY;
    logic [1:0]  RES_CH;
    logic [31:0] RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD;
    logic        RES_TIMEOUT;

    int checks   = 0;
    int failures = 0;
    int last_served = NUM_CH - 1;

    int ch_lo[NUM_CH]  = '{4, 4, 4, 4};
    int ch_hi[NUM_CH]  = '{4, 4, 4, 4};
    int ph_cnt[NUM_CH] = '{0, 0, 0, 0};
    bit ch_hold[NUM_CH] = '{0, 0, 0, 0};

    freq_channel_scheduler #(
        .NUM_CH(NUM_CH), .EDGES_PER_MEAS(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .CH_EN(CH_EN), .FREQ_IN_CH(freq),
        .FC_RST_N(FC_RST_N), .FC_FREQ_IN(FC_FREQ_IN),
        .FC_TIME_HIGH(fc_th), .FC_TIME_LOW(fc_tl), .FC_PERIOD(fc_per),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_CH(RES_CH),
        .RES_TIME_HIGH(RES_TIME_HIGH), .RES_TIME_LOW(RES_TIME_LOW),
        .RES_PERIOD(RES_PERIOD), .RES_TIMEOUT(RES_TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Square waves: ch_lo[i] cycles low, ch_hi[i] cycles high, or held low.
    initial begin
        freq = '0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_hold[i]) begin
                    freq[i] = 1'b0;
                    ph_cnt[i] = 0;
                end else begin
                    ph_cnt[i]++;
                    if (!freq[i] && ph_cnt[i] >= ch_lo[i]) begin
                        freq[i] = 1'b1; ph_cnt[i] = 0;
                    end else if (freq[i] && ph_cnt[i] >= ch_hi[i]) begin
                        freq[i] = 1'b0; ph_cnt[i] = 0;
                    end
                end
            end
        end
    end

    // Shared counter: reports the last complete high run and the low run that followed it.
    logic        fc_prev, fc_seen_rise, fc_have_high;
    logic [31:0] fc_hi_run, fc_lo_run, fc_last_high;
    always @(posedge CLK) begin
        if (!FC_RST_N) begin
            fc_prev <= FC_FREQ_IN; fc_seen_rise <= 1'b0; fc_have_high <= 1'b0;
            fc_hi_run <= '0; fc_lo_run <= '0; fc_last_high <= '0;
            fc_th <= '0; fc_tl <= '0; fc_per <= '0;
        end else begin
            fc_prev <= FC_FREQ_IN;
            if (FC_FREQ_IN && !fc_prev) begin
                if (fc_have_high) begin
                    fc_th <= fc_last_high; fc_tl <= fc_lo_run; fc_per <= fc_last_high + fc_lo_run;
                end
                fc_seen_rise <= 1'b1; fc_hi_run <= 32'd1; fc_lo_run <= '0;
            end else if (!FC_FREQ_IN && fc_prev) begin
                if (fc_seen_rise) begin
                    fc_last_high <= fc_hi_run; fc_have_high <= 1'b1;
                end
                fc_lo_run <= 32'd1; fc_hi_run <= '0;
            end else if (FC_FREQ_IN) fc_hi_run <= fc_hi_run + 32'd1;
            else                     fc_lo_run <= fc_lo_run + 32'd1;
        end
    end

    function automatic int next_ch(input int last, input logic [3:0] mask);
        next_ch = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (last + k) % NUM_CH;
            if (next_ch < 0 && ((mask >> c) & 4'd1) != 4'd0) next_ch = c;
        end
    endfunction

    task automatic tick();
        @(negedge CLK); #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (RES_VALID) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_rst_n(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (FC_RST_N === level) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic do_reset();
        RUN = 1'b0; RES_READY = 1'b0; RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        last_served = NUM_CH - 1;
        tick();
    endtask

    task automatic test_reset();
        RUN = 1'b0; CH_EN = '0; RES_READY = 1'b0; RST = 1'b1;
        tick(); tick();
        checks++; if (FC_RST_N !== 1'b0) begin failures++; $display("FAIL rst_fc_rst_n got=%b exp=0", FC_RST_N); end
        checks++; if (FC_FREQ_IN !== 1'b0) begin failures++; $display("FAIL rst_fc_freq got=%b exp=0", FC_FREQ_IN); end
        checks++; if (RES_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", RES_VALID); end
        checks++; if (RES_TIMEOUT !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", RES_TIMEOUT); end
        checks++; if (RES_CH !== 2'd0) begin failures++; $display("FAIL rst_ch got=%0d exp=0", RES_CH); end
        checks++; if ({RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD} !== 96'd0) begin
            failures++; $display("FAIL rst_data got=%0d/%0d/%0d exp=0/0/0", RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD); end
        RST = 1'b0; #1;
        checks++; if (FC_RST_N !== 1'b1) begin failures++; $display("FAIL rst_release_fc_rst_n got=%b exp=1", FC_RST_N); end
        tick();
        last_served = NUM_CH - 1;
    endtask

    task automatic test_single();
        bit ok;
        ch_lo[0] = 4; ch_hi[0] = 6;
        repeat (40) tick();
        CH_EN = 4'b0001; RUN = 1'b1;
        wait_valid(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_valid got=timeout exp=valid"); end
        checks++; if (RES_CH !== 2'd0) begin failures++; $display("FAIL single_ch got=%0d exp=0", RES_CH); end
        checks++; if (RES_TIME_LOW !== 32'd4) begin failures++; $display("FAIL single_low got=%0d exp=4", RES_TIME_LOW); end
        checks++; if (RES_TIME_HIGH !== 32'd6) begin failures++; $display("FAIL single_high got=%0d exp=6", RES_TIME_HIGH); end
        checks++; if (RES_PERIOD !== 32'd10) begin failures++; $display("FAIL single_period got=%0d exp=10", RES_PERIOD); end
        checks++; if (RES_TIMEOUT !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", RES_TIMEOUT); end
        RUN = 1'b0; RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        checks++; if (RES_VALID !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", RES_VALID); end
        last_served = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int lo, hi;
        logic [97:0] snap;
        lo = int'($urandom_range(9, 2)); hi = int'($urandom_range(9, 2));
        ch_lo[0] = lo; ch_hi[0] = hi;
        repeat (40) tick();
        CH_EN = 4'b0001; RUN = 1'b1;
        wait_rst_n(1'b0, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_start got=no_clear exp=clear"); end
        // Dropping RUN and the mask mid-measurement must not abort it.
        RUN = 1'b0; CH_EN = 4'b0000;
        wait_valid(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_valid got=timeout exp=valid"); end
        checks++; if ({RES_CH, RES_TIMEOUT} !== 3'b000) begin
            failures++; $display("FAIL bp_ch got=%0d/%b exp=0/0", RES_CH, RES_TIMEOUT); end
        checks++; if (RES_TIME_LOW !== 32'(lo) || RES_TIME_HIGH !== 32'(hi) || RES_PERIOD !== 32'(lo + hi)) begin
            failures++; $display("FAIL bp_data got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                RES_TIME_LOW, RES_TIME_HIGH, RES_PERIOD, lo, hi, lo + hi); end
        snap = {RES_CH, RES_TIMEOUT, RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD[30:0]};
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++; if (RES_VALID !== 1'b1 || FC_RST_N !== 1'b1 ||
                {RES_CH, RES_TIMEOUT, RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD[30:0]} !== snap) begin
                failures++; $display("FAIL bp_hold cycle=%0d got=v%b n%b ch%0d p%0d exp=v1 n1 ch0 p%0d",
                    i, RES_VALID, FC_RST_N, RES_CH, RES_PERIOD, lo + hi); end
        end
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        checks++; if (RES_VALID !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", RES_VALID); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (RES_VALID !== 1'b0 || FC_RST_N !== 1'b1 ||
                {RES_CH, RES_TIMEOUT, RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD[30:0]} !== snap) begin
                failures++; $display("FAIL bp_after got=v%b n%b p%0d exp=v0 n1 p%0d", RES_VALID, FC_RST_N, RES_PERIOD, lo + hi); end
        end
        last_served = 0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_ch;
        logic [3:0] masks[3];
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_lo[c] = int'($urandom_range(8, 2)); ch_hi[c] = int'($urandom_range(8, 2));
        end
        repeat (40) tick();
        masks[0] = 4'b1011;
        masks[1] = 4'($urandom_range(15, 1));
        masks[2] = 4'($urandom_range(15, 1));
        RES_READY = 1'b1;
        for (int r = 0; r < 3; r++) begin
            CH_EN = masks[r]; RUN = 1'b1;
            for (int n = 0; n < ((r == 0) ? 6 : 4); n++) begin
                exp_ch = next_ch(last_served, masks[r]);
                wait_valid(300, ok);
                checks++; if (!ok) begin failures++; $display("FAIL rr_valid round=%0d got=timeout exp=valid", r); end
                checks++; if (RES_CH !== 2'(exp_ch) || RES_TIMEOUT !== 1'b0) begin
                    failures++; $display("FAIL rr_ch mask=%b got=%0d/%b exp=%0d/0", masks[r], RES_CH, RES_TIMEOUT, exp_ch); end
                checks++; if (RES_TIME_LOW !== 32'(ch_lo[exp_ch]) || RES_TIME_HIGH !== 32'(ch_hi[exp_ch]) ||
                    RES_PERIOD !== 32'(ch_lo[exp_ch] + ch_hi[exp_ch])) begin
                    failures++; $display("FAIL rr_data ch=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", exp_ch,
                        RES_TIME_LOW, RES_TIME_HIGH, RES_PERIOD, ch_lo[exp_ch], ch_hi[exp_ch], ch_lo[exp_ch] + ch_hi[exp_ch]); end
                tick();
                checks++; if (RES_VALID !== 1'b0) begin failures++; $display("FAIL rr_spacing got=%b exp=0", RES_VALID); end
                last_served = exp_ch;
            end
        end
        RUN = 1'b0; RES_READY = 1'b0;
        repeat (300) begin
            if (!RES_VALID && FC_RST_N) break;
            tick();
        end
        RES_READY = 1'b1; tick(); RES_READY = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n_low, n;
        do_reset();
        ch_hold[0] = 1'b1;
        repeat (10) tick();
        CH_EN = 4'b0001; RUN = 1'b1;
        wait_rst_n(1'b0, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tmo_start got=no_clear exp=clear"); end
        RUN = 1'b0;
        n_low = 0;
        while (FC_RST_N === 1'b0 && n_low < 10) begin n_low++; tick(); end
        checks++; if (n_low != 2) begin failures++; $display("FAIL clear_len got=%0d exp=2", n_low); end
        n = 0;
        while (RES_VALID !== 1'b1 && n < 200) begin n++; tick(); end
        checks++; if (n != TMO) begin failures++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, TMO); end
        checks++; if (RES_TIMEOUT !== 1'b1 || RES_CH !== 2'd0) begin
            failures++; $display("FAIL tmo_flag got=%b/%0d exp=1/0", RES_TIMEOUT, RES_CH); end
        checks++; if ({RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD} !== 96'd0) begin
            failures++; $display("FAIL tmo_data got=%0d/%0d/%0d exp=0/0/0", RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD); end
        RES_READY = 1'b1; tick(); RES_READY = 1'b0;
        ch_hold[0] = 1'b0;
        last_served = 0;
    endtask

    task automatic test_reset_mid();
        bit ok, ok2;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            ch_lo[c] = int'($urandom_range(8, 2)); ch_hi[c] = int'($urandom_range(8, 2));
        end
        repeat (40) tick();
        CH_EN = 4'b1111; RES_READY = 1'b1; RUN = 1'b1;
        wait_valid(300, ok);
        checks++; if (!ok || RES_CH !== 2'd0) begin failures++; $display("FAIL rmid_first got=%b/%0d exp=1/0", ok, RES_CH); end
        tick();
        wait_rst_n(1'b0, 10, ok);
        wait_rst_n(1'b1, 10, ok2);
        checks++; if (!(ok && ok2)) begin failures++; $display("FAIL rmid_clear got=%b%b exp=11", ok, ok2); end
        repeat (3) tick();
        RST = 1'b1;
        tick();
        checks++; if (RES_VALID !== 1'b0 || FC_RST_N !== 1'b0 || FC_FREQ_IN !== 1'b0) begin
            failures++; $display("FAIL rmid_ctrl got=v%b n%b f%b exp=v0 n0 f0", RES_VALID, FC_RST_N, FC_FREQ_IN); end
        checks++; if (RES_CH !== 2'd0 || RES_TIMEOUT !== 1'b0 || {RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD} !== 96'd0) begin
            failures++; $display("FAIL rmid_data got=%0d/%b/%0d exp=0/0/0", RES_CH, RES_TIMEOUT, RES_PERIOD); end
        RST = 1'b0; #1;
        last_served = NUM_CH - 1;
        checks++; if (FC_RST_N !== 1'b1 || RES_VALID !== 1'b0) begin
            failures++; $display("FAIL rmid_release got=n%b v%b exp=n1 v0", FC_RST_N, RES_VALID); end
        tick();
        wait_valid(300, ok);
        checks++; if (!ok || RES_CH !== 2'd0) begin failures++; $display("FAIL rmid_next got=%b/%0d exp=1/0", ok, RES_CH); end
        checks++; if (RES_TIME_LOW !== 32'(ch_lo[0]) || RES_TIME_HIGH !== 32'(ch_hi[0])) begin
            failures++; $display("FAIL rmid_data2 got=%0d/%0d exp=%0d/%0d", RES_TIME_LOW, RES_TIME_HIGH, ch_lo[0], ch_hi[0]); end
        RUN = 1'b0;
        tick();
        RES_READY = 1'b0;
        last_served = 0;
    endtask

    task automatic test_idle();
        bit ok;
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            RUN   = (phase == 1);
            CH_EN = (phase == 1) ? 4'b0000 : 4'b1111;
            for (int i = 0; i < 1000; i++) begin
                RES_READY = 1'($urandom);
                tick();
                checks++; if (FC_RST_N !== 1'b1 || RES_VALID !== 1'b0 || FC_FREQ_IN !== 1'b0) begin
                    failures++; $display("FAIL idle phase=%0d cycle=%0d got=n%b v%b f%b exp=n1 v0 f0",
                        phase, i, FC_RST_N, RES_VALID, FC_FREQ_IN); end
            end
        end
        RES_READY = 1'b0;
        ch_lo[2] = 3; ch_hi[2] = 5;
        repeat (40) tick();
        CH_EN = 4'b0100; RUN = 1'b1;
        wait_valid(300, ok);
        checks++; if (!ok || RES_CH !== 2'd2 || RES_PERIOD !== 32'd8) begin
            failures++; $display("FAIL idle_resume got=%b/%0d/%0d exp=1/2/8", ok, RES_CH, RES_PERIOD); end
        RUN = 1'b0; RES_READY = 1'b1; tick(); RES_READY = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RUN = 1'b0; CH_EN = '0; RES_READY = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_channel_scheduler.md
FREQ_CHANNEL_SCHEDULER -- requirements
Module: freq_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of FREQ_IN channels sharing one frequency_counter.
REQ-002 SHALL have parameter EDGES_PER_MEAS, default 3: rising edges of the selected channel counted before capture, minimum 3.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: CLK cycles allowed per measurement before abort.
REQ-004 SHALL have port CLK  input  1  single clock for all logic.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port RUN  input  1  enables scheduling of new measurements.
REQ-007 SHALL have port CH_EN  input  NUM_CH  per-channel enable mask.
REQ-008 SHALL have port FREQ_IN_CH  input  NUM_CH  asynchronous channel signals.
REQ-009 SHALL have port FC_RST_N  output  1  active-low reset to the shared counter.
REQ-010 SHALL have port FC_FREQ_IN  output  1  selected synchronized channel, driven to the counter.
REQ-011 SHALL have ports FC_TIME_HIGH, FC_TIME_LOW, FC_PERIOD  input  32 each  counter results.
REQ-012 SHALL have port RES_VALID  output  1  result available.
REQ-013 SHALL have port RES_READY  input  1  consumer accepts result.
REQ-014 SHALL have port RES_CH  output  clog2(NUM_CH), minimum 1  channel index of the result.
REQ-015 SHALL have ports RES_TIME_HIGH, RES_TIME_LOW, RES_PERIOD  output  32 each  captured values.
REQ-016 SHALL have port RES_TIMEOUT  output  1  result was aborted by timeout.

Function
REQ-017 SHALL pass each FREQ_IN_CH bit through a 2-flop synchronizer; FC_FREQ_IN SHALL be the synchronized bit of the current channel, and SHALL be 0 in IDLE.
REQ-018 SHALL implement FSM states IDLE, CLEAR, MEASURE, SETTLE, OUTPUT.
REQ-019 IDLE: when RUN=1 and CH_EN!=0, SHALL select the next enabled channel round-robin, searching upward from last-served+1 with wrap from NUM_CH-1 to 0, then go to CLEAR. Otherwise it SHALL stay in IDLE.
REQ-020 The first selection after reset SHALL search from channel 0.
REQ-021 CLEAR: SHALL drive FC_RST_N=0 for exactly 2 cycles, clear the edge and timeout counters, then go to MEASURE.
REQ-022 MEASURE: SHALL count rising edges of the synchronized selected bit (previous 0, current 1). On reaching EDGES_PER_MEAS it SHALL go to SETTLE.
REQ-023 SETTLE: SHALL wait 2 cycles, then register the FC_* inputs, RES_CH and RES_TIMEOUT=0 into the result registers, then go to OUTPUT.
REQ-024 Timeout counter: SHALL increment each cycle in MEASURE. On reaching TIMEOUT_CYCLES it SHALL go to OUTPUT with RES_TIMEOUT=1 and RES_TIME_HIGH, RES_TIME_LOW and RES_PERIOD all 0.
REQ-025 OUTPUT: SHALL hold RES_VALID=1 with all RES_* outputs stable until a cycle with RES_READY=1, then deassert RES_VALID the next cycle and return to IDLE.
REQ-026 The RES_* data outputs SHALL hold their last value outside OUTPUT.
REQ-027 Changes to CH_EN or RUN mid-measurement SHALL NOT abort the measurement; they SHALL only affect the next selection in IDLE.
REQ-028 Minimum spacing between results SHALL be 1 IDLE cycle; the block SHALL NOT accept back-to-back handshakes without IDLE.
REQ-029 RES_READY asserted while RES_VALID=0 SHALL be ignored.

Reset
REQ-030 While RST=1, SHALL force state IDLE, FC_RST_N=0, FC_FREQ_IN=0, RES_VALID=0, RES_TIMEOUT=0, RES_CH=0, and all RES_* data outputs to 0.
REQ-031 SHALL clear the round-robin pointer and synchronizers on reset.
REQ-032 RST asserted mid-measurement or mid-OUTPUT SHALL discard the pending result with no RES_VALID pulse.
REQ-033 In the first cycle after RST falls, FC_RST_N SHALL be 1 while in IDLE.

Verification
REQ-034 Single channel: CH_EN=0001, RUN=1, ch0 at 4 cycles low / 6 cycles high, counter model attached -> RES_CH=0, RES_TIME_LOW=4, RES_TIME_HIGH=6, RES_PERIOD=10, RES_TIMEOUT=0.
REQ-035 Round-robin: CH_EN=1011, RES_READY=1 -> RES_CH sequence 0,1,3,0,1,3; channel 2 is never selected.
REQ-036 Timeout: TIMEOUT_CYCLES=100, ch0 held at 0 -> RES_VALID after 100 MEASURE cycles with RES_TIMEOUT=1 and all data 0.
REQ-037 Backpressure: RES_READY=0 for 50 cycles during OUTPUT -> RES_VALID and RES_* held constant, and FC_RST_N is not pulsed again until READY=1.
REQ-038 Reset mid-measurement: RST=1 for 1 cycle during MEASURE -> no RES_VALID, all outputs at reset values, next result comes from channel 0.
REQ-039 RUN=0 or CH_EN=0 -> the block remains in IDLE, FC_RST_N stays 1, RES_VALID stays 0 for 1000 cycles.
